// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_pkg
// Description : Shared constants and elaboration helpers for the segmented
//               pipelined adder/subtractor (stage count, width legality).
// Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_SEG_W = 16;

    // Number of pipeline stages; clamped to 1 so illegal settings still
    // elaborate far enough for the width check to report them.
    function automatic int unsigned stages_f(input int unsigned width,
                                             input int unsigned seg_w);
        int unsigned n;
        n = (seg_w == 0) ? 1 : (width / seg_w);
        return (n == 0) ? 1 : n;
    endfunction

    // True when the operand splits into a whole number of segments.
    function automatic bit width_ok(input int unsigned width,
                                    input int unsigned seg_w);
        return (seg_w != 0) && (width >= seg_w) && ((width % seg_w) == 0);
    endfunction

endpackage

`ifndef ADDER_WIDTH_CHECK
`define ADDER_WIDTH_CHECK(W, S) \
    if (!adder_pkg::width_ok((W), (S))) begin : g_width_check \
        $error("adder_pipe: WIDTH must be a non-zero multiple of SEG_W"); \
    end
`endif
`default_nettype wire

// File: rtl/adder_seg.sv
`default_nettype none
// ============================================================================
// Module      : adder_seg
// Description : Combinational SEG_W-bit adder slice. Returns the segment sum,
//               the carry out of the slice and the carry into its MSB.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_seg #(
    parameter int unsigned SEG_W = 16
) (
    input  logic [SEG_W-1:0] a_i,
    input  logic [SEG_W-1:0] b_i,
    input  logic             c_i,
    output logic [SEG_W-1:0] sum_o,
    output logic             c_msb_o,
    output logic             cout_o
);

    logic [SEG_W:0] w_full;

    // One extra bit catches the carry out of the slice.
    assign w_full = {1'b0, a_i} + {1'b0, b_i} + {{SEG_W{1'b0}}, c_i};

    assign sum_o   = w_full[SEG_W-1:0];
    assign cout_o  = w_full[SEG_W];
    // The MSB sum bit is a ^ b ^ carry_in, so the carry into it falls out
    // directly; this also works for a 1-bit slice.
    assign c_msb_o = w_full[SEG_W-1] ^ a_i[SEG_W-1] ^ b_i[SEG_W-1];

endmodule
`default_nettype wire

// File: rtl/adder_pipe.sv
`default_nettype none
// ============================================================================
// Module      : adder_pipe
// Description : Pipelined ripple-carry adder/subtractor. One SEG_W segment is
//               resolved per stage with the carry registered in between.
//               Unfinished operand bits travel down a shift register (skew)
//               and finished sum segments shift in from the top (deskew), so
//               the full result lines up at the last stage. valid/ready
//               handshake on both sides with a global stall.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_pipe
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SEG_W = DEF_SEG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic [WIDTH-1:0] din_one,
    input  logic [WIDTH-1:0] din_two,
    input  logic             cin,
    input  logic             sub,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned STAGES = stages_f(WIDTH, SEG_W);

    `ADDER_WIDTH_CHECK(WIDTH, SEG_W)

    // Per-stage pipeline registers; index k holds the state after stage k.
    logic             valid_q [STAGES];
    logic             carry_q [STAGES];
    logic             ovf_q   [STAGES];
    logic [WIDTH-1:0] opa_q   [STAGES];
    logic [WIDTH-1:0] opb_q   [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];

    logic adv;

    // The whole pipe moves unless a finished result is being refused.
    assign adv       = !(valid_q[STAGES-1] && !dout_ready);
    assign din_ready = adv;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            logic [WIDTH-1:0] a_in;
            logic [WIDTH-1:0] b_in;
            logic [WIDTH-1:0] s_in;
            logic             c_in;
            logic             v_in;
            logic [SEG_W-1:0] seg_sum;
            logic             seg_cout;
            logic             seg_cmsb;
            logic [WIDTH-1:0] seg_ext;
            logic [WIDTH-1:0] opa_d;
            logic [WIDTH-1:0] opb_d;
            logic [WIDTH-1:0] sum_d;
            logic             ovf_d;

            if (k == 0) begin : g_src_in
                // Stage 0 sees the raw operands; B is inverted up front for
                // subtraction and the +1 enters as the initial carry.
                assign a_in = din_one;
                assign b_in = sub ? ~din_two : din_two;
                assign c_in = sub ? 1'b1 : cin;
                assign v_in = din_valid;
                assign s_in = '0;
            end else begin : g_src_pipe
                assign a_in = opa_q[k-1];
                assign b_in = opb_q[k-1];
                assign c_in = carry_q[k-1];
                assign v_in = valid_q[k-1];
                assign s_in = sum_q[k-1];
            end

            adder_seg #(
                .SEG_W (SEG_W)
            ) u_seg (
                .a_i     (a_in[SEG_W-1:0]),
                .b_i     (b_in[SEG_W-1:0]),
                .c_i     (c_in),
                .sum_o   (seg_sum),
                .c_msb_o (seg_cmsb),
                .cout_o  (seg_cout)
            );

            // Next segment moves to the bottom of the skew registers; the new
            // sum segment enters at the top of the deskew register.
            assign seg_ext = WIDTH'(seg_sum);
            assign opa_d   = a_in >> SEG_W;
            assign opb_d   = b_in >> SEG_W;
            assign sum_d   = (s_in >> SEG_W) | (seg_ext << (WIDTH - SEG_W));
            assign ovf_d   = seg_cout ^ seg_cmsb;

            // Stage register: cleared on reset, frozen while stalled.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q[k] <= 1'b0;
                    carry_q[k] <= 1'b0;
                    ovf_q[k]   <= 1'b0;
                    opa_q[k]   <= '0;
                    opb_q[k]   <= '0;
                    sum_q[k]   <= '0;
                end else if (adv) begin
                    valid_q[k] <= v_in;
                    carry_q[k] <= seg_cout;
                    ovf_q[k]   <= ovf_d;
                    opa_q[k]   <= opa_d;
                    opb_q[k]   <= opb_d;
                    sum_q[k]   <= sum_d;
                end
            end
        end
    endgenerate

    assign dout_valid = valid_q[STAGES-1];
    assign sum        = sum_q[STAGES-1];
    assign cout       = carry_q[STAGES-1];
    assign ovf        = ovf_q[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_pipe
// Description : Directed self-checking bench for adder_pipe. Drives a default
//               32/16 instance and a 64/8 instance from shared stimulus; sel
//               picks which one receives din_valid and is observed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_pipe;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic        tb_valid;
    logic        tb_dready;
    logic [63:0] tb_a;
    logic [63:0] tb_b;
    logic        tb_cin;
    logic        tb_sub;

    logic        rdy32, dv32, co32, ov32;
    logic [31:0] sum32;
    logic        rdy64, dv64, co64, ov64;
    logic [63:0] sum64;

    logic        m_drdy, m_dv, m_cout, m_ovf;
    logic [63:0] m_sum;

    int n_cmp  = 0;
    int n_fail = 0;

    adder_pipe u_dut32 (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (tb_valid && !sel),
        .din_ready  (rdy32),
        .din_one    (tb_a[31:0]),
        .din_two    (tb_b[31:0]),
        .cin        (tb_cin),
        .sub        (tb_sub),
        .dout_valid (dv32),
        .dout_ready (tb_dready),
        .sum        (sum32),
        .cout       (co32),
        .ovf        (ov32)
    );

    adder_pipe #(
        .WIDTH (64),
        .SEG_W (8)
    ) u_dut64 (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (tb_valid && sel),
        .din_ready  (rdy64),
        .din_one    (tb_a),
        .din_two    (tb_b),
        .cin        (tb_cin),
        .sub        (tb_sub),
        .dout_valid (dv64),
        .dout_ready (tb_dready),
        .sum        (sum64),
        .cout       (co64),
        .ovf        (ov64)
    );

    assign m_drdy = sel ? rdy64 : rdy32;
    assign m_dv   = sel ? dv64  : dv32;
    assign m_sum  = sel ? sum64 : {32'd0, sum32};
    assign m_cout = sel ? co64  : co32;
    assign m_ovf  = sel ? ov64  : ov32;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference result packed as {ovf, cout, sum}.
    function automatic logic [65:0] model(input bit wide, input logic [63:0] a,
                                          input logic [63:0] b, input logic c, input logic s);
        logic [63:0] bb;
        logic        ci;
        logic [64:0] f64;
        logic [32:0] f32;
        bb = s ? ~b : b;
        ci = s ? 1'b1 : c;
        if (wide) begin
            f64 = {1'b0, a} + {1'b0, bb} + {64'd0, ci};
            return {(a[63] == bb[63]) && (f64[63] != a[63]), f64[64], f64[63:0]};
        end
        f32 = {1'b0, a[31:0]} + {1'b0, bb[31:0]} + {32'd0, ci};
        return {(a[31] == bb[31]) && (f32[31] != a[31]), f32[32], 32'd0, f32[31:0]};
    endfunction

    // One isolated transaction on an empty pipe; called at posedge+1.
    task automatic txn(input bit wide, input logic [63:0] a, input logic [63:0] b,
                       input logic c, input logic s, input logic [63:0] es,
                       input logic ec, input logic eo, input string tag);
        int n;
        sel = wide; tb_a = a; tb_b = b; tb_cin = c; tb_sub = s;
        tb_valid = 1'b1; tb_dready = 1'b1;
        #1;
        chk({tag, ".ready"}, {65'd0, m_drdy}, 66'd1);
        @(posedge clk); #1;
        tb_valid = 1'b0;
        n = 0;
        while (m_dv !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".latency"}, 66'(n), wide ? 66'd7 : 66'd1);
        chk({tag, ".sum"},  {2'b00, m_sum}, {2'b00, es});
        chk({tag, ".cout"}, {65'd0, m_cout}, {65'd0, ec});
        chk({tag, ".ovf"},  {65'd0, m_ovf},  {65'd0, eo});
        @(posedge clk); #1;
        chk({tag, ".drained"}, {65'd0, m_dv}, 66'd0);
    endtask

    // 8 random vectors streamed with dout_ready cycling 1,0,0,1.
    task automatic sweep(input bit wide, input string tag);
        logic [63:0] va [8];
        logic [63:0] vb [8];
        logic        vc [8];
        logic        vs [8];
        logic [65:0] ve [8];
        logic [65:0] held;
        bit          hold;
        bit          in_fire;
        int          in_i, out_i, cyc, extra;
        for (int i = 0; i < 8; i++) begin
            va[i] = wide ? {$urandom(), $urandom()} : {32'd0, $urandom()};
            vb[i] = wide ? {$urandom(), $urandom()} : {32'd0, $urandom()};
            vc[i] = 1'($urandom_range(0, 1));
            vs[i] = 1'($urandom_range(0, 1));
            ve[i] = model(wide, va[i], vb[i], vc[i], vs[i]);
        end
        sel = wide; in_i = 0; out_i = 0; cyc = 0; hold = 0; held = '0;
        while (out_i < 8 && cyc < 200) begin
            tb_dready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            tb_valid  = (in_i < 8);
            if (in_i < 8) begin
                tb_a = va[in_i]; tb_b = vb[in_i]; tb_cin = vc[in_i]; tb_sub = vs[in_i];
            end
            #1;
            chk({tag, ".ready_tracks"}, {65'd0, m_drdy}, {65'd0, !(m_dv && !tb_dready)});
            if (hold)
                chk({tag, ".stable"}, {m_ovf, m_cout, m_sum}, held);
            hold = m_dv && !tb_dready;
            held = {m_ovf, m_cout, m_sum};
            if (m_dv && tb_dready) begin
                if (out_i < 8)
                    chk({tag, ".result"}, {m_ovf, m_cout, m_sum}, ve[out_i]);
                out_i++;
            end
            in_fire = tb_valid && m_drdy;
            @(posedge clk); #1;
            if (in_fire) in_i++;
            cyc++;
        end
        tb_valid = 1'b0; tb_dready = 1'b1;
        chk({tag, ".count"}, 66'(out_i), 66'd8);
        extra = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (m_dv) extra++;
        end
        chk({tag, ".no_extra"}, 66'(extra), 66'd0);
    endtask

    initial begin
        int n_emit;
        rst_n = 1'b1; sel = 1'b0; tb_valid = 1'b0; tb_dready = 1'b1;
        tb_a = '0; tb_b = '0; tb_cin = 1'b0; tb_sub = 1'b0;
        #3 rst_n = 1'b0;
        #5;
        chk("reset.dv32",  {65'd0, dv32},  66'd0);
        chk("reset.dv64",  {65'd0, dv64},  66'd0);
        chk("reset.ready", {65'd0, rdy32}, 66'd1);
        chk("reset.sum",   {34'd0, sum32}, 66'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        txn(0, 64'hFFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0,         1'b1, 1'b0, "t1_wrap");
        txn(0, 64'h5,         64'h7, 1'b0, 1'b1, 64'hFFFF_FFFE, 1'b0, 1'b0, "t2_sub_neg");
        txn(0, 64'h8000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF, 1'b1, 1'b1, "t2_sub_ovf");
        txn(0, 64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000, 1'b0, 1'b1, "t3_add_ovf");
        txn(0, 64'h0000_FFFF, 64'h0, 1'b1, 1'b0, 64'h0001_0000, 1'b0, 1'b0, "seg_carry");
        txn(0, 64'hA,         64'h3, 1'b1, 1'b1, 64'h7,         1'b1, 1'b0, "sub_ign_cin");

        sweep(0, "t4_sweep32");

        // Two results in flight, output stalled, then reset mid-cycle.
        sel = 1'b0; tb_dready = 1'b0; tb_valid = 1'b1;
        tb_a = 64'h1; tb_b = 64'h2; tb_cin = 1'b0; tb_sub = 1'b0;
        @(posedge clk); #1;
        tb_a = 64'h3; tb_b = 64'h4;
        @(posedge clk); #1;
        tb_valid = 1'b0;
        chk("t5.inflight_dv",    {65'd0, m_dv},   66'd1);
        chk("t5.inflight_ready", {65'd0, m_drdy}, 66'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5.rst_dv",    {65'd0, m_dv},   66'd0);
        chk("t5.rst_ready", {65'd0, m_drdy}, 66'd1);
        chk("t5.rst_sum",   {2'b00, m_sum},  66'd0);
        chk("t5.rst_cout",  {65'd0, m_cout}, 66'd0);
        tb_dready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        n_emit = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (m_dv) n_emit++;
        end
        chk("t5.no_emit", 66'(n_emit), 66'd0);
        txn(0, 64'h1234_5678, 64'h1111_1111, 1'b0, 1'b0, 64'h2345_6789, 1'b0, 1'b0, "t5_after");

        txn(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, "t6_wrap64");
        txn(1, 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1,
            64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, "t6_sub_ovf64");
        sweep(1, "t6_sweep64");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
